mem_wb_queue: RTL
=================

Name: mem_wb_queue

Overview:
- Writeback buffer between the MEM unit and the CDB.
- ALU writebacks take priority on the CDB, so MEM results would otherwise be lost whenever both units finish in the same cycle. This block buffers MEM results in a small FIFO and presents one entry per cycle on the CDB's MEM-side inputs.
- An entry drains only in a cycle when the ALU is not writing.
- A starvation counter forces an ALU stall so that queued MEM results cannot be blocked indefinitely.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- STARVE_LIMIT, 8, consecutive blocked cycles before ALU stall is requested.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Valid_MEM_WBQ  in  1  MEM result valid this cycle
- WarpID_MEM_WBQ  in  3  hardware warp ID
- RegWrite_MEM_WBQ  in  1  result writes a register
- Dst_MEM_WBQ  in  5  destination register
- Dst_Data_MEM_WBQ  in  256  8 lanes x 32b data
- Instr_MEM_WBQ  in  32  instruction word
- ActiveMask_MEM_WBQ  in  8  lane active mask
- ScbID_MEM_WBQ  in  2  scoreboard entry to clear
- Ready_WBQ_MEM  out  1  queue can accept an entry this cycle
- RegWrite_ALU_CDB  in  1  ALU is using the CDB this cycle
- Valid_WBQ_CDB  out  1  head entry presented
- WarpID_MEM_CDB  out  3  head warp ID
- RegWrite_MEM_CDB  out  1  head RegWrite gated with Valid_WBQ_CDB
- Dst_MEM_CDB  out  5  head destination register
- Dst_Data_MEM_CDB  out  256  head data
- Instr_MEM_CDB  out  32  head instruction word
- ActiveMask_MEM_CDB  out  8  head active mask
- Clear_ScbID_MEM_CDB  out  2  head scoreboard ID
- Stall_WBQ_ALU  out  1  request ALU to hold its writeback

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - Write pointer, read pointer and count = 0.
  - Starve counter = 0; Stall_WBQ_ALU = 0.
  - Valid_WBQ_CDB = 0; Ready_WBQ_MEM = 1 from the first cycle after reset.
  - All CDB data outputs are 0.
- Reset mid-operation discards all queued entries; no partial drain occurs.
- Ready: Ready_WBQ_MEM = (count < DEPTH). It is decoded from registered count only, so there is no combinational path from any input.
- Enqueue: enq = Valid_MEM_WBQ & Ready_WBQ_MEM. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Protocol violation: Valid_MEM_WBQ while Ready_WBQ_MEM=0 is illegal. The input is ignored and the bench flags it with an assertion.
- Head presentation:
  - Valid_WBQ_CDB = (count != 0).
  - Outputs show the entry at rd_ptr; all data outputs are forced to 0 when count = 0.
  - RegWrite_MEM_CDB = Valid_WBQ_CDB & stored RegWrite.
- Latency: an entry enqueued in cycle N is visible on the outputs at cycle N+1 at the earliest. There is no bypass from input to output.
- Dequeue: deq = Valid_WBQ_CDB & ~RegWrite_ALU_CDB. rd_ptr increments modulo DEPTH.
- Entries with RegWrite=0 (for example, stores) still occupy a slot and dequeue under the same rule. This preserves order and delivers their scoreboard clear.
- Count update:
  - Increments on enq only; decrements on deq only.
  - Unchanged on simultaneous enq and deq, including when count = DEPTH-1 or when count = 1.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
- Starvation:
  - The counter increments each cycle in which Valid_WBQ_CDB=1 and deq=0, saturating at STARVE_LIMIT.
  - It clears to 0 on any deq, or whenever count = 0.
  - Stall_WBQ_ALU is a register: set on the cycle after the counter reaches STARVE_LIMIT, and cleared on the cycle after a deq.
  - The ALU is expected to drop RegWrite_ALU_CDB while stalled.
- Ordering: strict FIFO, with no reordering by warp.

Decomposition:
- Shared package holds:
  - Widths: WARP_W=3, REG_W=5, LANES=8, DATA_W=256, INSTR_W=32, SCB_W=2.
  - A packed writeback-entry struct (warp, regwrite, dst, data, instr, mask, scbid). The CDB and ALU-side queues reuse this struct.
- One natural sub-module, wb_fifo: a parameterised storage array with pointers and count. The top level adds the grant and starvation logic.

Test Plan:
- Reset, then no traffic -> Ready=1, Valid_WBQ_CDB=0, RegWrite_MEM_CDB=0, Stall=0, all data outputs 0.
- Single enqueue (warp 5, dst 3, data 256'hA5.., scb 2) with ALU idle -> outputs show that entry the next cycle; it dequeues that same cycle and Valid drops one cycle later.
- ALU busy 3 cycles while 4 entries are enqueued back-to-back -> Ready=0 after the 4th; when the ALU goes idle, entries drain in enqueue order at 1 per cycle and Ready returns to 1 after the first drain.
- Simultaneous enq and deq at count=3 over 6 cycles -> count stays at 3, pointers wrap past 3 to 0, output order is preserved.
- ALU busy continuously with 1 entry queued -> Stall_WBQ_ALU=1 in cycle 9 after the head first appears; the ALU drops RegWrite, the entry drains, and Stall=0 the following cycle.
- Reset asserted with 3 entries queued and Stall=1 -> the next cycle has count 0, Valid=0, Stall=0, Ready=1, and no stale entry appears afterward.

Source files
------------

// File: rtl/mem_wb_queue_pkg.sv
// Shared widths and the writeback-entry record used by the MEM writeback
// queue and its CDB-side consumers.
package mem_wb_queue_pkg;

  localparam int unsigned WARP_W  = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned LANES   = 8;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SCB_W   = 2;

  // One writeback result as it travels toward the CDB.
  typedef struct packed {
    logic [WARP_W-1:0]  warp;
    logic               regwrite;
    logic [REG_W-1:0]   dst;
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
    logic [LANES-1:0]   mask;
    logic [SCB_W-1:0]   scbid;
  } wb_entry_t;

  // Presents an entry only when it is valid; otherwise all fields read as zero.
  function automatic wb_entry_t wb_gate(input wb_entry_t e, input logic v);
    return v ? e : '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Storage array with read/write pointers and occupancy count for the
// writeback queue. The caller guarantees enq_i only when not full and
// deq_i only when not empty.
module wb_fifo
  import mem_wb_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_i,
  input  logic             deq_i,
  input  wb_entry_t        wr_entry_i,
  output wb_entry_t        rd_entry_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq_i) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({enq_i, deq_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since an empty queue masks them.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  assign rd_entry_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/mem_wb_queue.sv
// MEM writeback queue: buffers MEM results that lose CDB arbitration to the
// ALU, drains one entry per ALU-idle cycle, and requests an ALU stall when
// the head has been blocked for too long.
module mem_wb_queue
  import mem_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Valid_MEM_WBQ,
  input  logic [WARP_W-1:0]   WarpID_MEM_WBQ,
  input  logic                RegWrite_MEM_WBQ,
  input  logic [REG_W-1:0]    Dst_MEM_WBQ,
  input  logic [DATA_W-1:0]   Dst_Data_MEM_WBQ,
  input  logic [INSTR_W-1:0]  Instr_MEM_WBQ,
  input  logic [LANES-1:0]    ActiveMask_MEM_WBQ,
  input  logic [SCB_W-1:0]    ScbID_MEM_WBQ,
  output logic                Ready_WBQ_MEM,
  input  logic                RegWrite_ALU_CDB,
  output logic                Valid_WBQ_CDB,
  output logic [WARP_W-1:0]   WarpID_MEM_CDB,
  output logic                RegWrite_MEM_CDB,
  output logic [REG_W-1:0]    Dst_MEM_CDB,
  output logic [DATA_W-1:0]   Dst_Data_MEM_CDB,
  output logic [INSTR_W-1:0]  Instr_MEM_CDB,
  output logic [LANES-1:0]    ActiveMask_MEM_CDB,
  output logic [SCB_W-1:0]    Clear_ScbID_MEM_CDB,
  output logic                Stall_WBQ_ALU
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  wb_entry_t        in_entry;
  wb_entry_t        head_entry;
  wb_entry_t        cdb_entry;
  logic [CNT_W-1:0] count;
  logic             ready;
  logic             valid;
  logic             enq;
  logic             deq;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  // Pack the MEM-side inputs into one queue entry.
  always_comb begin
    in_entry          = '0;
    in_entry.warp     = WarpID_MEM_WBQ;
    in_entry.regwrite = RegWrite_MEM_WBQ;
    in_entry.dst      = Dst_MEM_WBQ;
    in_entry.data     = Dst_Data_MEM_WBQ;
    in_entry.instr    = Instr_MEM_WBQ;
    in_entry.mask     = ActiveMask_MEM_WBQ;
    in_entry.scbid    = ScbID_MEM_WBQ;
  end

  // Handshake decode; ready and valid depend on the registered count only.
  always_comb begin
    ready = (count < DEPTH_C);
    valid = (count != '0);
    enq   = Valid_MEM_WBQ & ready;
    deq   = valid & ~RegWrite_ALU_CDB;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .enq_i      (enq),
    .deq_i      (deq),
    .wr_entry_i (in_entry),
    .rd_entry_o (head_entry),
    .count_o    (count)
  );

  // Head presentation; an empty queue drives zeros on every CDB field.
  always_comb begin
    cdb_entry           = wb_gate(head_entry, valid);
    Ready_WBQ_MEM       = ready;
    Valid_WBQ_CDB       = valid;
    WarpID_MEM_CDB      = cdb_entry.warp;
    RegWrite_MEM_CDB    = cdb_entry.regwrite;
    Dst_MEM_CDB         = cdb_entry.dst;
    Dst_Data_MEM_CDB    = cdb_entry.data;
    Instr_MEM_CDB       = cdb_entry.instr;
    ActiveMask_MEM_CDB  = cdb_entry.mask;
    Clear_ScbID_MEM_CDB = cdb_entry.scbid;
    Stall_WBQ_ALU       = stall_q;
  end

  // Starvation tracking: count blocked head cycles; stall follows the
  // saturated counter one cycle later and drops the cycle after a drain.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (!valid || deq) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    if (deq) begin
      stall_d = 1'b0;
    end else if (starve_q == STARVE_MAX) begin
      stall_d = 1'b1;
    end
  end

  // Starvation counter and stall request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

endmodule
